// File: rtl/id_ex_operand_stage_pkg.sv
// id_ex_operand_stage_pkg: shared pipeline constants for the ID/EX operand stage
package id_ex_operand_stage_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_NOR  = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_SLTU = 3'b111;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
endpackage

// File: rtl/id_ex_operand_stage_operand_forward.sv
// operand_forward: picks the freshest value of one source register from EX/MEM, MEM/WB or the stored read
module operand_forward
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic [REG_W-1:0]  src,
    input  logic [DATA_W-1:0] stored,
    input  logic              exmem_reg_write,
    input  logic [REG_W-1:0]  exmem_write_reg,
    input  logic [DATA_W-1:0] exmem_alu_result,
    input  logic              memwb_reg_write,
    input  logic [REG_W-1:0]  memwb_write_reg,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [1:0]        sel,
    output logic [DATA_W-1:0] value
);
    logic exmem_hit;
    logic memwb_hit;

    // Younger EX/MEM producer wins over MEM/WB; register 0 is never forwarded
    always_comb begin
        exmem_hit = exmem_reg_write && exmem_write_reg != '0 && exmem_write_reg == src;
        memwb_hit = memwb_reg_write && memwb_write_reg != '0 && memwb_write_reg == src;
        sel       = exmem_hit ? FWD_EXMEM : memwb_hit ? FWD_MEMWB : FWD_RF;
        value     = exmem_hit ? exmem_alu_result : memwb_hit ? memwb_result : stored;
    end
endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with RAW forwarding into the ALU operands
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [2:0]        id_alu_control,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              exmem_reg_write,
    input  logic [REG_W-1:0]  exmem_write_reg,
    input  logic [DATA_W-1:0] exmem_alu_result,
    input  logic              memwb_reg_write,
    input  logic [REG_W-1:0]  memwb_write_reg,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_control,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_W-1:0]  ex_write_reg,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);
    logic              alu_src_q;
    logic [DATA_W-1:0] rd1_q;
    logic [DATA_W-1:0] rd2_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] fwd_rs_value;
    logic [DATA_W-1:0] fwd_rt_value;

    // Reset and flush load an all-zero bubble; stall holds; otherwise capture decode
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            alu_control   <= ALU_ADD;
            alu_src_q     <= 1'b0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_write_reg  <= '0;
            rd1_q         <= '0;
            rd2_q         <= '0;
            imm_q         <= '0;
        end else if (!stall) begin
            ex_valid      <= id_valid;
            ex_reg_write  <= id_reg_write;
            ex_mem_read   <= id_mem_read;
            ex_mem_write  <= id_mem_write;
            ex_mem_to_reg <= id_mem_to_reg;
            alu_control   <= id_alu_control;
            alu_src_q     <= id_alu_src;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_write_reg  <= id_reg_dst ? id_rd : id_rt;
            rd1_q         <= id_rd1;
            rd2_q         <= id_rd2;
            imm_q         <= id_imm;
        end
    end

    operand_forward #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs (
        .src              (ex_rs),
        .stored           (rd1_q),
        .exmem_reg_write  (exmem_reg_write),
        .exmem_write_reg  (exmem_write_reg),
        .exmem_alu_result (exmem_alu_result),
        .memwb_reg_write  (memwb_reg_write),
        .memwb_write_reg  (memwb_write_reg),
        .memwb_result     (memwb_result),
        .sel              (fwd_a),
        .value            (fwd_rs_value)
    );

    operand_forward #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rt (
        .src              (ex_rt),
        .stored           (rd2_q),
        .exmem_reg_write  (exmem_reg_write),
        .exmem_write_reg  (exmem_write_reg),
        .exmem_alu_result (exmem_alu_result),
        .memwb_reg_write  (memwb_reg_write),
        .memwb_write_reg  (memwb_write_reg),
        .memwb_result     (memwb_result),
        .sel              (fwd_b),
        .value            (fwd_rt_value)
    );

    // Store data always takes the forwarded rt, even when B uses the immediate
    always_comb begin
        alu_a         = fwd_rs_value;
        alu_b         = alu_src_q ? imm_q : fwd_rt_value;
        ex_store_data = fwd_rt_value;
    end
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: vector table, directed stall/flush/reset sequences and randomized model checks
module tb_id_ex_operand_stage;
    logic        clk, rst, stall, flush, id_valid;
    logic [31:0] id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [2:0]  id_alu_control;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_write_reg, memwb_write_reg;
    logic [31:0] exmem_alu_result, memwb_result;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [2:0]  alu_control;
    logic [4:0]  ex_write_reg, ex_rs, ex_rt;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [1:0]  fwd_a, fwd_b;

    int n_checks = 0;
    int n_fail = 0;

    logic        m_valid, m_rw, m_mr, m_mw, m_m2r, m_src;
    logic [2:0]  m_alu;
    logic [4:0]  m_rs, m_rt, m_wr;
    logic [31:0] m_rd1, m_rd2, m_imm;

    typedef struct {
        logic [4:0]  rs, rt, rd;
        logic [31:0] rd1, rd2, imm;
        logic        src, dst;
        logic [2:0]  alu;
        logic        xm_we;
        logic [4:0]  xm_reg;
        logic [31:0] xm_val;
        logic        wb_we;
        logic [4:0]  wb_reg;
        logic [31:0] wb_val;
        logic [31:0] exp_a, exp_b, exp_st;
        logic [1:0]  exp_fa, exp_fb;
        logic [4:0]  exp_wr;
    } vec_t;

    vec_t vecs[7];

    id_ex_operand_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu_control(id_alu_control), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .exmem_write_reg(exmem_write_reg),
        .exmem_alu_result(exmem_alu_result),
        .memwb_reg_write(memwb_reg_write), .memwb_write_reg(memwb_write_reg),
        .memwb_result(memwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .ex_store_data(ex_store_data),
        .ex_write_reg(ex_write_reg), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference forwarding: newest writer of a nonzero register supplies the value
    function automatic logic [33:0] fwd_ref(input logic [4:0] src, input logic [31:0] stored);
        if (src != 0 && exmem_reg_write && exmem_write_reg == src) return {2'b10, exmem_alu_result};
        if (src != 0 && memwb_reg_write && memwb_write_reg == src) return {2'b01, memwb_result};
        return {2'b00, stored};
    endfunction

    task automatic model_edge();
        if (rst || flush) begin
            {m_valid, m_rw, m_mr, m_mw, m_m2r, m_src} = '0;
            m_alu = '0; m_rs = '0; m_rt = '0; m_wr = '0;
            m_rd1 = '0; m_rd2 = '0; m_imm = '0;
        end else if (!stall) begin
            {m_valid, m_rw, m_mr, m_mw, m_m2r, m_src} =
                {id_valid, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src};
            m_alu = id_alu_control; m_rs = id_rs; m_rt = id_rt;
            m_wr = id_reg_dst ? id_rd : id_rt;
            m_rd1 = id_rd1; m_rd2 = id_rd2; m_imm = id_imm;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [33:0] fa, fb;
        fa = fwd_ref(m_rs, m_rd1);
        fb = fwd_ref(m_rt, m_rd2);
        check({tag, ".alu_a"}, alu_a, fa[31:0]);
        check({tag, ".alu_b"}, alu_b, m_src ? m_imm : fb[31:0]);
        check({tag, ".store"}, ex_store_data, fb[31:0]);
        check({tag, ".fwd"}, 32'({fwd_a, fwd_b}), 32'({fa[33:32], fb[33:32]}));
        check({tag, ".alu_ctl"}, 32'(alu_control), 32'(m_alu));
        check({tag, ".regs"}, 32'({ex_rs, ex_rt, ex_write_reg}), 32'({m_rs, m_rt, m_wr}));
        check({tag, ".flags"}, 32'({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}),
              32'({m_valid, m_rw, m_mr, m_mw, m_m2r}));
    endtask

    task automatic rand_id(input int reg_max);
        id_valid = 1'($urandom); id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
        id_rs = 5'($urandom_range(0, reg_max)); id_rt = 5'($urandom_range(0, reg_max));
        id_rd = 5'($urandom_range(0, 31));
        id_alu_control = 3'($urandom); id_alu_src = 1'($urandom); id_reg_dst = 1'($urandom);
        id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
        id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
    endtask

    task automatic rand_prod();
        exmem_reg_write = 1'($urandom); exmem_write_reg = 5'($urandom_range(0, 5));
        exmem_alu_result = $urandom;
        memwb_reg_write = 1'($urandom); memwb_write_reg = 5'($urandom_range(0, 5));
        memwb_result = $urandom;
    endtask

    task automatic clear_prod();
        {exmem_reg_write, memwb_reg_write} = '0;
        exmem_write_reg = '0; memwb_write_reg = '0;
        exmem_alu_result = '0; memwb_result = '0;
    endtask

    initial begin
        vecs[0] = '{1, 2, 9, 5, 7, 0, 0, 1, 3'b001, 0, 0, 0, 0, 0, 0, 5, 7, 7, 0, 0, 9};
        vecs[1] = '{3, 2, 0, 1, 2, 0, 0, 0, 3'b000, 1, 3, 'h11, 1, 3, 'h22, 'h11, 2, 2, 2, 0, 2};
        vecs[2] = '{3, 2, 0, 1, 2, 0, 0, 0, 3'b000, 0, 3, 'h11, 1, 3, 'h22, 'h22, 2, 2, 1, 0, 2};
        vecs[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 3'b010, 1, 0, 'hFF, 1, 0, 'hEE, 0, 0, 0, 0, 0, 0};
        vecs[4] = '{1, 4, 0, 'h10, 'h20, 'hFFFFFFFC, 1, 0, 3'b000, 0, 0, 0, 1, 4, 'hAB,
                    'h10, 'hFFFFFFFC, 'hAB, 0, 1, 4};
        vecs[5] = '{6, 7, 31, 1, 2, 0, 0, 1, 3'b110, 1, 7, 'h77, 1, 6, 'h66, 'h66, 'h77, 'h77, 1, 2, 31};
        vecs[6] = '{5, 5, 0, 'hA, 'hB, 0, 0, 0, 3'b111, 0, 5, 1, 0, 5, 2, 'hA, 'hB, 'hB, 0, 0, 5};

        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        rand_id(31); clear_prod();
        model_edge();

        for (int i = 0; i < 2; i++) begin
            rand_id(31); rand_prod();
            tick();
            check("reset.alu_a", alu_a, 0);
            check("reset.alu_b", alu_b, 0);
            check("reset.fwd", 32'({fwd_a, fwd_b}), 0);
            check("reset.valid", 32'(ex_valid), 0);
            check_model("reset");
        end
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            clear_prod();
            id_valid = 1'b1; id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_rd = vecs[i].rd;
            id_rd1 = vecs[i].rd1; id_rd2 = vecs[i].rd2; id_imm = vecs[i].imm;
            id_alu_src = vecs[i].src; id_reg_dst = vecs[i].dst; id_alu_control = vecs[i].alu;
            {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg} = 4'b1000;
            tick();
            exmem_reg_write = vecs[i].xm_we; exmem_write_reg = vecs[i].xm_reg;
            exmem_alu_result = vecs[i].xm_val;
            memwb_reg_write = vecs[i].wb_we; memwb_write_reg = vecs[i].wb_reg;
            memwb_result = vecs[i].wb_val;
            #1;
            check($sformatf("vec%0d.alu_a", i), alu_a, vecs[i].exp_a);
            check($sformatf("vec%0d.alu_b", i), alu_b, vecs[i].exp_b);
            check($sformatf("vec%0d.store", i), ex_store_data, vecs[i].exp_st);
            check($sformatf("vec%0d.fwd_a", i), 32'(fwd_a), 32'(vecs[i].exp_fa));
            check($sformatf("vec%0d.fwd_b", i), 32'(fwd_b), 32'(vecs[i].exp_fb));
            check($sformatf("vec%0d.write_reg", i), 32'(ex_write_reg), 32'(vecs[i].exp_wr));
            check($sformatf("vec%0d.alu_ctl", i), 32'(alu_control), 32'(vecs[i].alu));
            check($sformatf("vec%0d.valid", i), 32'(ex_valid), 1);
        end

        clear_prod();
        id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd12; id_reg_dst = 1'b1;
        id_rd1 = 32'hA0A0_0001; id_rd2 = 32'hB0B0_0002; id_imm = '0; id_alu_src = 1'b0;
        id_alu_control = 3'b011; {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg} = 4'b1000;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_id(31);
            tick();
            check("stall.alu_a", alu_a, 32'hA0A0_0001);
            check("stall.alu_b", alu_b, 32'hB0B0_0002);
            check("stall.write_reg", 32'(ex_write_reg), 12);
            check("stall.alu_ctl", 32'(alu_control), 3);
            check_model("stall");
        end
        flush = 1'b1;
        rand_id(31);
        tick();
        check("flush.valid", 32'(ex_valid), 0);
        check("flush.reg_write", 32'(ex_reg_write), 0);
        check("flush.alu_ctl", 32'(alu_control), 0);
        check_model("flush");
        stall = 1'b0; flush = 1'b0;

        rand_id(31); id_valid = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check("midrst.valid", 32'(ex_valid), 0);
        check_model("midrst");
        rst = 1'b0;
        id_valid = 1'b1; id_rs = 5'd7; id_rd1 = 32'h1234_5678; id_alu_control = 3'b101;
        tick();
        check("afterrst.alu_a", alu_a, 32'h1234_5678);
        check("afterrst.valid", 32'(ex_valid), 1);
        check("afterrst.alu_ctl", 32'(alu_control), 5);

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 19) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 3) == 0);
            rand_id(5);
            rand_prod();
            tick();
            rand_prod();
            #1;
            check_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-forwarding logic; sits directly upstream of the execute-stage ALU and drives its A, B and ALUControl inputs.
- Captures decoded operands and control from the decode stage once per clock.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB results.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- DATA_W, 32, datapath width.
- REG_W, 5, register-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold all stage registers.
- flush  in  1  load a bubble on the next edge.
- id_valid  in  1  decode slot holds a real instruction.
- id_rd1, id_rd2  in  DATA_W  register-file read data for rs and rt.
- id_imm  in  DATA_W  sign-extended immediate.
- id_rs, id_rt, id_rd  in  REG_W  source and destination register numbers.
- id_alu_control  in  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor, 110 slt, 111 sltu.
- id_alu_src  in  1  1 selects the immediate for operand B.
- id_reg_dst  in  1  1 selects rd as the write register, 0 selects rt.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control flags.
- exmem_reg_write  in  1  EX/MEM producer writes a register.
- exmem_write_reg  in  REG_W  EX/MEM destination register.
- exmem_alu_result  in  DATA_W  EX/MEM result.
- memwb_reg_write  in  1  MEM/WB producer writes a register.
- memwb_write_reg  in  REG_W  MEM/WB destination register.
- memwb_result  in  DATA_W  MEM/WB result.
- alu_a, alu_b  out  DATA_W  ALU operands.
- alu_control  out  3  ALU op.
- ex_store_data  out  DATA_W  forwarded rt value, for stores.
- ex_write_reg  out  REG_W  selected destination register.
- ex_rs, ex_rt  out  REG_W  registered source numbers, for the hazard unit.
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each.
- fwd_a, fwd_b  out  2  forwarding selects: 00 register file, 01 MEM/WB, 10 EX/MEM.

Behaviour:
- Priority at each rising edge: rst > flush > stall > load.
- rst or flush: every registered field is cleared to 0, including valid, all control flags, alu_control (=000), rs/rt/rd, data and immediate. A bubble is therefore an add of 0+0 with no side effects.
- flush together with stall: flush wins.
- stall (no rst, no flush): all registers hold their values.
- load: all id_* fields are captured. ex_write_reg is computed at capture time as id_reg_dst ? id_rd : id_rt.
- Latency: exactly 1 cycle from id_* inputs to ex_* outputs.
- Forwarding is combinational from the registered rs/rt and the current exmem_/memwb_ inputs. For operand X in {rs, rt}:
  - select 10 if exmem_reg_write && exmem_write_reg != 0 && exmem_write_reg == X;
  - else 01 if memwb_reg_write && memwb_write_reg != 0 && memwb_write_reg == X;
  - else 00.
  - EX/MEM has priority over MEM/WB because it is the younger producer.
  - Register 0 is never forwarded; it always reads the stored rd1/rd2.
- alu_a = forwarded rs.
- alu_b = alu_src ? imm : forwarded rt.
- ex_store_data = forwarded rt, regardless of alu_src.
- Forwarding is active even when ex_valid=0; the outputs are harmless because all control flags are 0.
- System rule: stall is asserted only when EX/MEM and MEM/WB are frozen as well, so forwarded sources stay stable while this stage holds.
- The register file's same-cycle write/read bypass lives in decode, not in this block.
- Reset mid-operation: the in-flight instruction is discarded; the next edge after rst deasserts captures id_* normally.

Decomposition:
- Shared pipeline package holds:
  - ALU op constants ALU_ADD..ALU_SLTU (3-bit);
  - forwarding select constants FWD_RF=00, FWD_MEMWB=01, FWD_EXMEM=10;
  - DATA_W and REG_W defaults.
- One combinational sub-module, operand_forward: inputs are the source register number, the stored value and both producer triples; outputs are the 2-bit select and the forwarded value. It is instantiated twice (rs, rt).

Test Plan:
- Reset: rst=1 for 2 cycles with random id_* -> all outputs 0, alu_control=000, fwd_a=fwd_b=00.
- Plain load: id_rd1=5, id_rd2=7, alu_src=0, alu_control=001, reg_dst=1, rd=9; no producers -> next cycle alu_a=5, alu_b=7, alu_control=001, ex_write_reg=9.
- Forwarding priority: ex_rs=3; exmem (we=1, reg=3, val=0x11) and memwb (we=1, reg=3, val=0x22) -> alu_a=0x11, fwd_a=10. Then exmem_we=0 -> alu_a=0x22, fwd_a=01.
- Register 0: ex_rt=0, exmem (we=1, reg=0, val=0xFF), stored rd2=0 -> alu_b=0, fwd_b=00.
- Immediate with store: alu_src=1, imm=0xFFFFFFFC, rt=4, memwb (we=1, reg=4, val=0xAB) -> alu_b=0xFFFFFFFC, ex_store_data=0xAB.
- Stall/flush: load instruction A, stall=1 for 3 cycles while id_* changes -> outputs stay A. Then flush=1 with stall=1 -> next cycle ex_valid=0, ex_reg_write=0, alu_control=000.
